// File: rtl/corescore_uart_pkg.sv
// Shared definitions for the corescore UART emitter and receiver:
// receiver FSM states, data width and the baud divider calculation.
package corescore_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Clocks per bit period, truncating.
  function automatic int calc_bit_clks(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/corescore_uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; both flops reset
// to the idle-high line level.
module corescore_uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  // Shift the raw pin through two flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/corescore_receiver_uart.sv
// UART 8N1 receiver with mid-bit sampling, framing check and a one-entry
// output holding register. Define CORESCORE_UART_RX_PARITY_EN for 8E1.
module corescore_receiver_uart
  import corescore_uart_pkg::*;
#(
  parameter int clk_freq_hz = 16_000_000,
  parameter int baud_rate   = 57600
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_uart_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
`ifdef CORESCORE_UART_RX_PARITY_EN
  output logic              o_parity_err,
`endif
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int BIT_CLKS  = calc_bit_clks(clk_freq_hz, baud_rate);
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (BIT_CLKS < 4) begin : g_bit_clks_check
    $error("corescore_receiver_uart: clk_freq_hz / baud_rate must be >= 4");
  end

  logic rxs;

  corescore_uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_uart_rx),
    .o_q   (rxs)
  );

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              stop_ok_s;
  logic              byte_done_s;

  assign stop_ok_s = (state_q == ST_STOP) && (cnt_q == '0) && rxs;

`ifdef CORESCORE_UART_RX_PARITY_EN
  logic parity_q;
  logic parity_err_q;
  logic parity_ok_s;
  assign parity_ok_s  = ((^shift_q) ^ parity_q) == 1'b0;
  assign byte_done_s  = stop_ok_s && parity_ok_s;
  assign o_parity_err = parity_err_q;
`else
  assign byte_done_s  = stop_ok_s;
`endif

  // Receive FSM: start validation, bit sampling and stop check.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef CORESCORE_UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef CORESCORE_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q <= ST_START;
            cnt_q   <= HALF_RELOAD;
          end
        end
        ST_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!rxs) begin
            state_q   <= ST_DATA;
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= 3'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            shift_q   <= {rxs, shift_q[DATA_W-1:1]};
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef CORESCORE_UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef CORESCORE_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            parity_q <= rxs;
            cnt_q    <= BIT_RELOAD;
            state_q  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
`ifdef CORESCORE_UART_RX_PARITY_EN
            parity_err_q <= !parity_ok_s;
`endif
            if (rxs) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Holding register: a completed byte loads if the slot is free or drains this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (byte_done_s) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;

endmodule
